// File: rtl/md_unit_gen2_if.sv
`default_nettype none
// ============================================================================
// Module      : md_unit_gen2_if
// Description : Bundles the operand, control and result signals of the
//               multiply/divide unit. clk and rst stay separate ports.
//               Signal directions are named from the unit's point of view:
//                 start_i    launch an op (taken only while idle)
//                 op_i       operation code (MULT..MSUBU)
//                 src_a_i    multiplicand / dividend / MTHI-MTLO data
//                 src_b_i    multiplier / divisor
//                 hilo_we_i  MTHI/MTLO write strobe
//                 hilo_sel_i 0 = write Lo, 1 = write Hi
//                 flush_i    abort the in-flight op
//                 busy_o     op in flight
//                 hi_o/lo_o  Hi / Lo registers
//                 div_by_zero_o  last completed divide had a zero divisor
//               master = pipeline side, slave = the unit itself.
// Revision    : 1.0 - initial release
// ============================================================================
interface md_unit_gen2_if #(
   parameter int WIDTH = 32
);
   logic             start_i;
   logic [2:0]       op_i;
   logic [WIDTH-1:0] src_a_i;
   logic [WIDTH-1:0] src_b_i;
   logic             hilo_we_i;
   logic             hilo_sel_i;
   logic             flush_i;
   logic             busy_o;
   logic [WIDTH-1:0] hi_o;
   logic [WIDTH-1:0] lo_o;
   logic             div_by_zero_o;

   modport master (
      output start_i, op_i, src_a_i, src_b_i, hilo_we_i, hilo_sel_i, flush_i,
      input  busy_o, hi_o, lo_o, div_by_zero_o
   );

   modport slave (
      input  start_i, op_i, src_a_i, src_b_i, hilo_we_i, hilo_sel_i, flush_i,
      output busy_o, hi_o, lo_o, div_by_zero_o
   );
endinterface
`default_nettype wire

// File: rtl/md_unit_gen2.sv
`default_nettype none
// ============================================================================
// Module      : md_unit_gen2
// Description : Multi-cycle multiply/divide unit for the EX stage.
//               Multiply-class ops (MULT/MULTU/MADD/MADDU/MSUB/MSUBU) hold
//               busy for MUL_LAT cycles and commit {hi,lo} at the end.
//               Divides run a WIDTH-step restoring divider on magnitudes
//               followed by one sign-correction cycle (WIDTH+1 busy cycles).
//               Ports:
//                 clk  - clock, all state updates on the rising edge
//                 rst  - synchronous active-high reset
//                 bus  - md_unit_gen2_if.slave (operands, control, results)
// Revision    : 1.0 - initial release
// ============================================================================
module md_unit_gen2 #(
   parameter int WIDTH   = 32,
   parameter int MUL_LAT = 5,
   parameter int CNT_W   = 6
) (
   input  logic            clk,
   input  logic            rst,
   md_unit_gen2_if.slave   bus
);

   localparam int W2 = 2 * WIDTH;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_MUL    = 2'd1,
      S_DIV    = 2'd2,
      S_DIVFIX = 2'd3
   } state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             busy_q, busy_d;
   logic             dbz_q, dbz_d;
   logic [WIDTH-1:0] hi_q, hi_d;
   logic [WIDTH-1:0] lo_q, lo_d;
   logic [2:0]       op_q, op_d;
   // For multiplies a_q/b_q hold the raw operands. For divides a_q holds the
   // dividend magnitude and doubles as the quotient shift register, while
   // b_q holds the divisor magnitude.
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] rem_q, rem_d;
   logic             dvd_neg_q, dvd_neg_d;   // remainder must be negated
   logic             quo_neg_q, quo_neg_d;   // quotient must be negated

   // ---------------- incoming-op decode ----------------
   logic             sgn_in;
   logic             div_in;
   logic [WIDTH-1:0] a_abs_in;
   logic [WIDTH-1:0] b_abs_in;

   assign sgn_in   = ~bus.op_i[0];
   assign div_in   = (bus.op_i[2:1] == 2'b01);
   assign a_abs_in = (sgn_in && bus.src_a_i[WIDTH-1]) ? -bus.src_a_i : bus.src_a_i;
   assign b_abs_in = (sgn_in && bus.src_b_i[WIDTH-1]) ? -bus.src_b_i : bus.src_b_i;

   // ---------------- multiply datapath ----------------
   logic             mul_sgn;
   logic [W2-1:0]    ext_a;
   logic [W2-1:0]    ext_b;
   logic [W2-1:0]    prod;
   logic [W2-1:0]    acc;
   logic [W2-1:0]    mul_res;

   assign mul_sgn = ~op_q[0];
   assign ext_a   = {{WIDTH{mul_sgn & a_q[WIDTH-1]}}, a_q};
   assign ext_b   = {{WIDTH{mul_sgn & b_q[WIDTH-1]}}, b_q};
   // Low 2*WIDTH bits of the sign/zero-extended product equal the true
   // signed or unsigned product modulo 2^(2*WIDTH).
   assign prod    = ext_a * ext_b;
   assign acc     = {hi_q, lo_q};

   always_comb begin
      case (op_q[2:1])
         2'b10:   mul_res = acc + prod;   // MADD / MADDU
         2'b11:   mul_res = acc - prod;   // MSUB / MSUBU
         default: mul_res = prod;         // MULT / MULTU
      endcase
   end

   // ---------------- restoring divide step ----------------
   logic [WIDTH:0]   shifted;
   logic [WIDTH:0]   diff;
   logic             no_borrow;

   assign shifted   = {rem_q, a_q[WIDTH-1]};
   assign diff      = shifted - {1'b0, b_q};
   assign no_borrow = ~diff[WIDTH];

   // ---------------- next-state / output logic ----------------
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      busy_d    = busy_q;
      dbz_d     = dbz_q;
      hi_d      = hi_q;
      lo_d      = lo_q;
      op_d      = op_q;
      a_d       = a_q;
      b_d       = b_q;
      rem_d     = rem_q;
      dvd_neg_d = dvd_neg_q;
      quo_neg_d = quo_neg_q;

      if (state_q != S_IDLE && bus.flush_i) begin
         // Abort wins over a same-cycle commit; results stay untouched.
         state_d = S_IDLE;
         busy_d  = 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (bus.start_i && !bus.flush_i) begin
                  op_d   = bus.op_i;
                  busy_d = 1'b1;
                  dbz_d  = 1'b0;
                  if (div_in) begin
                     state_d   = S_DIV;
                     cnt_d     = CNT_W'(WIDTH - 1);
                     a_d       = a_abs_in;
                     b_d       = b_abs_in;
                     rem_d     = '0;
                     dvd_neg_d = sgn_in & bus.src_a_i[WIDTH-1];
                     quo_neg_d = sgn_in & (bus.src_a_i[WIDTH-1] ^ bus.src_b_i[WIDTH-1]);
                  end else begin
                     state_d = S_MUL;
                     cnt_d   = CNT_W'(MUL_LAT - 1);
                     a_d     = bus.src_a_i;
                     b_d     = bus.src_b_i;
                  end
               end else if (bus.hilo_we_i) begin
                  if (bus.hilo_sel_i) begin
                     hi_d = bus.src_a_i;
                  end else begin
                     lo_d = bus.src_a_i;
                  end
               end
            end

            S_MUL: begin
               if (cnt_q == '0) begin
                  {hi_d, lo_d} = mul_res;
                  state_d      = S_IDLE;
                  busy_d       = 1'b0;
               end else begin
                  cnt_d = cnt_q - 1'b1;
               end
            end

            S_DIV: begin
               rem_d = no_borrow ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
               a_d   = {a_q[WIDTH-2:0], no_borrow};
               if (cnt_q == '0) begin
                  state_d = S_DIVFIX;
               end else begin
                  cnt_d = cnt_q - 1'b1;
               end
            end

            S_DIVFIX: begin
               // A zero divisor magnitude means the original divisor was 0.
               if (b_q == '0) begin
                  dbz_d = 1'b1;
               end else begin
                  lo_d = quo_neg_q ? -a_q   : a_q;
                  hi_d = dvd_neg_q ? -rem_q : rem_q;
               end
               state_d = S_IDLE;
               busy_d  = 1'b0;
            end

            default: begin
               state_d = S_IDLE;
               busy_d  = 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         busy_q    <= 1'b0;
         dbz_q     <= 1'b0;
         hi_q      <= '0;
         lo_q      <= '0;
         op_q      <= '0;
         a_q       <= '0;
         b_q       <= '0;
         rem_q     <= '0;
         dvd_neg_q <= 1'b0;
         quo_neg_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         busy_q    <= busy_d;
         dbz_q     <= dbz_d;
         hi_q      <= hi_d;
         lo_q      <= lo_d;
         op_q      <= op_d;
         a_q       <= a_d;
         b_q       <= b_d;
         rem_q     <= rem_d;
         dvd_neg_q <= dvd_neg_d;
         quo_neg_q <= quo_neg_d;
      end
   end

   assign bus.busy_o        = busy_q;
   assign bus.hi_o          = hi_q;
   assign bus.lo_o          = lo_q;
   assign bus.div_by_zero_o = dbz_q;

endmodule
`default_nettype wire

// File: tb/tb_md_unit_gen2.sv
`default_nettype none
// ============================================================================
// Module      : tb_md_unit_gen2
// Description : Self-checking bench for md_unit_gen2 (WIDTH=32, MUL_LAT=5).
//               Directed cases followed by randomized ops, all compared
//               against an arithmetic reference model of Hi/Lo/div_by_zero.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_md_unit_gen2;

   localparam int WIDTH   = 32;
   localparam int MUL_LAT = 5;
   localparam int CNT_W   = 6;
   localparam int DIV_LAT = WIDTH + 1;

   localparam logic [2:0] OP_MULT  = 3'b000;
   localparam logic [2:0] OP_MULTU = 3'b001;
   localparam logic [2:0] OP_DIV   = 3'b010;
   localparam logic [2:0] OP_DIVU  = 3'b011;
   localparam logic [2:0] OP_MADD  = 3'b100;
   localparam logic [2:0] OP_MADDU = 3'b101;
   localparam logic [2:0] OP_MSUB  = 3'b110;
   localparam logic [2:0] OP_MSUBU = 3'b111;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   md_unit_gen2_if #(.WIDTH(WIDTH)) bus ();

   md_unit_gen2 #(
      .WIDTH  (WIDTH),
      .MUL_LAT(MUL_LAT),
      .CNT_W  (CNT_W)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   int n_vec = 0;
   int n_err = 0;

   // Reference model state
   logic [31:0] m_hi, m_lo;
   logic        m_dbz;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Architectural effect of one completed op on Hi/Lo/div_by_zero.
   function automatic void model_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      longint      sa, sb;
      logic [63:0] prod, acc;
      sa  = longint'($signed(a));
      sb  = longint'($signed(b));
      acc = {m_hi, m_lo};
      if (op == OP_DIV || op == OP_DIVU) begin
         m_dbz = (b == 32'd0);
         if (b != 32'd0) begin
            if (op == OP_DIV) begin
               m_lo = 32'(sa / sb);
               m_hi = 32'(sa % sb);
            end else begin
               m_lo = a / b;
               m_hi = a % b;
            end
         end
      end else begin
         m_dbz = 1'b0;
         if (op == OP_MULT || op == OP_MADD || op == OP_MSUB)
            prod = 64'(sa * sb);
         else
            prod = {32'd0, a} * {32'd0, b};
         case (op)
            OP_MADD, OP_MADDU: {m_hi, m_lo} = acc + prod;
            OP_MSUB, OP_MSUBU: {m_hi, m_lo} = acc - prod;
            default:           {m_hi, m_lo} = prod;
         endcase
      end
   endfunction

   task automatic hilo_write(input logic sel, input logic [31:0] val);
      bus.hilo_we_i  = 1'b1;
      bus.hilo_sel_i = sel;
      bus.src_a_i    = val;
      tick();
      bus.hilo_we_i  = 1'b0;
      if (sel) m_hi = val; else m_lo = val;
   endtask

   task automatic launch(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      bus.start_i = 1'b1;
      bus.op_i    = op;
      bus.src_a_i = a;
      bus.src_b_i = b;
      tick();
      bus.start_i = 1'b0;
      // Scramble operands: the unit must use the values latched at start.
      bus.src_a_i = $urandom;
      bus.src_b_i = $urandom;
   endtask

   // Wait out busy, then check latency and results. 'already' is the number
   // of busy cycles the caller has consumed since launch.
   task automatic finish(input string tag, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input int already);
      int cyc;
      int lat;
      lat = (op == OP_DIV || op == OP_DIVU) ? DIV_LAT : MUL_LAT;
      cyc = 0;
      while (bus.busy_o === 1'b1 && cyc < 200) begin
         cyc++;
         tick();
      end
      chk({tag, " latency"}, 64'(cyc + already), 64'(lat));
      model_op(op, a, b);
      chk({tag, " hi"}, 64'(bus.hi_o), 64'(m_hi));
      chk({tag, " lo"}, 64'(bus.lo_o), 64'(m_lo));
      chk({tag, " dbz"}, 64'(bus.div_by_zero_o), 64'(m_dbz));
   endtask

   task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b);
      launch(op, a, b);
      finish(tag, op, a, b, 0);
   endtask

   function automatic logic [31:0] pick_operand();
      case ($urandom_range(0, 5))
         0:       return 32'd0;
         1:       return 32'hFFFF_FFFF;
         2:       return 32'h8000_0000;
         3:       return 32'($urandom_range(1, 20));
         default: return $urandom;
      endcase
   endfunction

   initial begin
      rst            = 1'b1;
      bus.start_i    = 1'b0;
      bus.op_i       = 3'b000;
      bus.src_a_i    = '0;
      bus.src_b_i    = '0;
      bus.hilo_we_i  = 1'b0;
      bus.hilo_sel_i = 1'b0;
      bus.flush_i    = 1'b0;
      m_hi = '0; m_lo = '0; m_dbz = 1'b0;
      tick();
      tick();
      chk("reset busy", 64'(bus.busy_o), 64'd0);
      chk("reset hi", 64'(bus.hi_o), 64'd0);
      chk("reset lo", 64'(bus.lo_o), 64'd0);
      chk("reset dbz", 64'(bus.div_by_zero_o), 64'd0);
      rst = 1'b0;
      tick();

      // Multiply
      run_op("mult", OP_MULT, 32'hFFFF_FFFE, 32'd3);
      chk("mult hi const", 64'(bus.hi_o), 64'hFFFF_FFFF);
      chk("mult lo const", 64'(bus.lo_o), 64'hFFFF_FFFA);
      run_op("multu", OP_MULTU, 32'hFFFF_FFFE, 32'd3);
      chk("multu hi const", 64'(bus.hi_o), 64'h2);
      chk("multu lo const", 64'(bus.lo_o), 64'hFFFF_FFFA);

      // Divide
      run_op("div neg", OP_DIV, 32'hFFFF_FFF9, 32'd2);
      chk("div neg lo const", 64'(bus.lo_o), 64'hFFFF_FFFD);
      chk("div neg hi const", 64'(bus.hi_o), 64'hFFFF_FFFF);
      run_op("divu", OP_DIVU, 32'd100, 32'd7);
      chk("divu lo const", 64'(bus.lo_o), 64'd14);
      chk("divu hi const", 64'(bus.hi_o), 64'd2);
      run_op("div min", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
      chk("div min lo const", 64'(bus.lo_o), 64'h8000_0000);
      chk("div min hi const", 64'(bus.hi_o), 64'h0);

      // Divide by zero, then a multiply start clears the flag
      hilo_write(1'b1, 32'h11);
      hilo_write(1'b0, 32'h22);
      run_op("divu zero", OP_DIVU, 32'd5, 32'd0);
      chk("dbz hi const", 64'(bus.hi_o), 64'h11);
      chk("dbz lo const", 64'(bus.lo_o), 64'h22);
      chk("dbz flag const", 64'(bus.div_by_zero_o), 64'd1);
      launch(OP_MULT, 32'd6, 32'd7);
      chk("dbz cleared at start", 64'(bus.div_by_zero_o), 64'd0);
      finish("mult after dbz", OP_MULT, 32'd6, 32'd7, 0);

      // Accumulate
      hilo_write(1'b1, 32'd0);
      hilo_write(1'b0, 32'hFFFF_FFFF);
      run_op("maddu", OP_MADDU, 32'd1, 32'd1);
      chk("maddu hi const", 64'(bus.hi_o), 64'd1);
      chk("maddu lo const", 64'(bus.lo_o), 64'd0);
      hilo_write(1'b1, 32'd0);
      hilo_write(1'b0, 32'd0);
      run_op("msub", OP_MSUB, 32'd1, 32'd1);
      chk("msub hi const", 64'(bus.hi_o), 64'hFFFF_FFFF);
      chk("msub lo const", 64'(bus.lo_o), 64'hFFFF_FFFF);

      // Flush in busy cycle 3
      hilo_write(1'b1, 32'hAAAA_0001);
      hilo_write(1'b0, 32'h5555_0002);
      launch(OP_DIV, 32'd1000, 32'd3);
      tick();
      tick();
      bus.flush_i = 1'b1;
      tick();
      bus.flush_i = 1'b0;
      chk("flush busy", 64'(bus.busy_o), 64'd0);
      chk("flush hi", 64'(bus.hi_o), 64'(m_hi));
      chk("flush lo", 64'(bus.lo_o), 64'(m_lo));
      run_op("after flush", OP_MADD, 32'hFFFF_FFF0, 32'd9);

      // Start while busy is ignored
      launch(OP_MULTU, 32'd7, 32'd9);
      bus.start_i = 1'b1;
      bus.op_i    = OP_DIVU;
      bus.src_a_i = 32'd50;
      bus.src_b_i = 32'd0;
      tick();
      bus.start_i = 1'b0;
      finish("start while busy", OP_MULTU, 32'd7, 32'd9, 1);

      // Reset mid-divide
      launch(OP_DIV, 32'd12345, 32'd11);
      repeat (5) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      m_hi = '0; m_lo = '0; m_dbz = 1'b0;
      chk("rst mid busy", 64'(bus.busy_o), 64'd0);
      chk("rst mid hi", 64'(bus.hi_o), 64'd0);
      chk("rst mid lo", 64'(bus.lo_o), 64'd0);

      // Hi/Lo writes
      hilo_write(1'b1, 32'h1234_5678);
      chk("mthi", 64'(bus.hi_o), 64'h1234_5678);
      hilo_write(1'b0, 32'h0BAD_F00D);
      chk("mtlo", 64'(bus.lo_o), 64'h0BAD_F00D);
      launch(OP_DIVU, 32'd5, 32'd0);
      bus.hilo_we_i  = 1'b1;
      bus.hilo_sel_i = 1'b0;
      bus.src_a_i    = 32'hDEAD_BEEF;
      tick();
      bus.hilo_we_i  = 1'b0;
      finish("write while busy", OP_DIVU, 32'd5, 32'd0, 1);
      hilo_write(1'b1, 32'h11);
      bus.start_i    = 1'b1;
      bus.hilo_we_i  = 1'b1;
      bus.hilo_sel_i = 1'b1;
      bus.op_i       = OP_DIVU;
      bus.src_a_i    = 32'd5;
      bus.src_b_i    = 32'd0;
      tick();
      bus.start_i    = 1'b0;
      bus.hilo_we_i  = 1'b0;
      finish("start+write", OP_DIVU, 32'd5, 32'd0, 0);
      chk("start+write hi const", 64'(bus.hi_o), 64'h11);

      // Randomized ops and Hi/Lo writes against the model
      for (int i = 0; i < 60; i++) begin
         if ($urandom_range(0, 9) < 2) begin
            hilo_write(1'($urandom_range(0, 1)), $urandom);
         end else begin
            run_op("random", 3'($urandom_range(0, 7)), pick_operand(), pick_operand());
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire
